core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Shares one AHB-Lite master port between the core's instruction-fetch port and its load/store data port.
- Arbitrates between the two requesters and runs one non-pipelined AHB transfer at a time: address phase, data phase, then a response cycle.
- Sits between the multi-cycle RISC-V core and the AHB bus.
- Each requester holds its request until it sees a one-cycle ack carrying read data and error status.

Parameters:
ADDR_W, 32, address width of requesters and HADDR
DATA_W, 32, data width of HWDATA/HRDATA and requester data
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed data-port priority

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
i_req  input  1  instruction fetch request, held until i_ack
i_addr  input  ADDR_W  fetch address, stable while i_req
i_ack  output  1  one-cycle fetch completion pulse
i_rdata  output  DATA_W  fetched word, valid while i_ack
i_err  output  1  bus error on fetch, valid while i_ack
d_req  input  1  data request, held until d_ack
d_we  input  1  1 = store, 0 = load
d_size  input  2  0 = byte, 1 = half, 2 = word
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ack  output  1  one-cycle data completion pulse
d_rdata  output  DATA_W  load data, valid while d_ack
d_err  output  1  bus error on data access, valid while d_ack
HADDR  output  ADDR_W  AHB address
HTRANS  output  2  AHB transfer type (IDLE = 00, NONSEQ = 10 only)
HWRITE  output  1  AHB write
HSIZE  output  3  AHB size
HWDATA  output  DATA_W  AHB write data
HRDATA  input  DATA_W  AHB read data
HREADY  input  1  AHB ready
HRESP  input  1  AHB error response

Behaviour:
- Reset values:
  - State IDLE.
  - HTRANS = 00; HADDR, HWDATA, HWRITE, HSIZE = 0.
  - i_ack, d_ack, i_err, d_err = 0; i_rdata, d_rdata = 0.
  - Round-robin pointer last_grant = DATA, so the instruction port wins the first tie.
- All outputs are registered.
- IDLE:
  - Sample i_req/d_req.
  - Only one request: grant it.
  - Both requests with RR_EN=1: grant the port not in last_grant.
  - Both requests with RR_EN=0: grant data.
  - On grant:
    - Latch owner, address, write, size and wdata.
    - Update last_grant.
    - Go to ADDR.
  - No request: stay in IDLE with HTRANS=00.
- ADDR:
  - Drive HTRANS=10 and HADDR = latched address.
  - HWRITE = d_we for data, 0 for instruction.
  - HSIZE = {1'b0, d_size} for data, 010 for instruction.
  - Hold every address-phase signal until a cycle with HREADY=1, then go to DATA.
- DATA:
  - Drive HTRANS=00; HADDR/HWRITE/HSIZE may stay at their held values.
  - Drive HWDATA = latched wdata for stores.
  - Wait for HREADY=1, then:
    - Capture HRDATA into the owner's rdata (loads/fetches only; stores leave rdata unchanged).
    - Capture HRESP into the owner's err.
    - Go to RESP.
  - Two-cycle AHB error (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) completes on the second cycle with err=1.
- RESP:
  - Owner's ack = 1 for exactly one cycle; the other port's ack stays 0.
  - Requests are not sampled in this cycle.
  - Return to IDLE.
  - Requester drops or changes req at the edge ending the ack cycle.
- Latency with zero-wait slave: req sampled at edge E0 → ADDR in cycle after E0 → DATA after E1 → ack high in the cycle after E2. Ack is therefore 3 cycles after the sampling edge. Minimum transfer period is 4 cycles.
- Each wait state (HREADY=0) in ADDR or DATA adds exactly one cycle.
- Request attributes changing while not owner: ignored until grant. The owner's attributes are latched at grant; later changes have no effect on the transfer in flight.
- Requests deasserted while another transfer is in progress: not served; no ack.
- No alignment checking; HADDR is passed through unchanged.
- Asynchronous reset mid-transfer:
  - Immediately returns to reset values and IDLE.
  - No ack is issued for the aborted transfer.
  - HTRANS=00 during and after reset.

Test Plan:
1. Fetch only, i_addr=0x0000_0100, zero-wait slave returning HRDATA=0x0010_0093 → HTRANS=10 with HADDR=0x100, HSIZE=010, HWRITE=0 for one cycle; i_ack=1 with i_rdata=0x0010_0093 in the 3rd cycle after the sampling edge; d_ack stays 0.
2. Store, d_addr=0x2000_0004, d_size=1, d_wdata=0xDEAD_BEEF, HREADY low 2 cycles in the data phase → HWRITE=1, HSIZE=001, HWDATA=0xDEAD_BEEF held through the wait; d_ack arrives 2 cycles later than in scenario 1; d_err=0.
3. i_req and d_req both held continuously, RR_EN=1 → grants alternate I, D, I, D starting with I. With RR_EN=0 → data is always granted and fetch waits until d_req drops.
4. Load to 0x3000_0000; slave gives HRESP=1/HREADY=0, then HRESP=1/HREADY=1 → d_ack=1 with d_err=1; next transfer's err is 0.
5. Assert reset while in DATA → all outputs return to reset values asynchronously; no ack is issued. After release, a pending i_req is granted first.
6. Change d_addr from 0x40 to 0x80 during the ADDR wait state (HREADY=0) → HADDR stays at 0x40 until completion.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// Core-side requester ports and AHB-Lite master port of the memory arbiter.
interface core_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Instruction fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  // Load/store data port
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  // AHB-Lite master port
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  // Arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
    input  HRDATA, HREADY, HRESP,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  // Core + bus environment view
  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
    output HRDATA, HREADY, HRESP,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one non-pipelined AHB-Lite master between fetch and load/store ports.
module core_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  core_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_grant;
  logic              w_sel_d;
  logic [1:0]        w_htrans_nxt;
  logic              w_i_ack_nxt;
  logic              w_d_ack_nxt;
  logic              w_hwdata_ld;
  logic              w_capture;

  logic              r_owner_d;
  logic              r_last_d;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_err;
  logic              r_d_err;

  // Grant only from IDLE; on a tie pick data unless round-robin says fetch's turn
  assign w_grant = (r_state == S_IDLE) && (bus.i_req || bus.d_req);
  assign w_sel_d = bus.d_req && (!bus.i_req || !RR_EN || !r_last_d);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: one transfer per grant, HREADY advances each phase
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)     w_state_nxt = S_ADDR;
      S_ADDR:  if (bus.HREADY)  w_state_nxt = S_DATA;
      S_DATA:  if (bus.HREADY)  w_state_nxt = S_RESP;
      S_RESP:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus/ack outputs
  always_comb begin
    w_htrans_nxt = HTRANS_IDLE;
    w_i_ack_nxt  = 1'b0;
    w_d_ack_nxt  = 1'b0;
    w_hwdata_ld  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: if (w_grant) w_htrans_nxt = HTRANS_NONSEQ;
      S_ADDR: begin
        if (!bus.HREADY) w_htrans_nxt = HTRANS_NONSEQ;
        else             w_hwdata_ld  = r_hwrite;
      end
      S_DATA: begin
        if (bus.HREADY) begin
          w_capture   = 1'b1;
          w_i_ack_nxt = !r_owner_d;
          w_d_ack_nxt = r_owner_d;
        end
      end
      default: ;
    endcase
  end

  // Control outputs and arbitration history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_htrans  <= HTRANS_IDLE;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b1;
    end else begin
      r_htrans <= w_htrans_nxt;
      r_i_ack  <= w_i_ack_nxt;
      r_d_ack  <= w_d_ack_nxt;
      if (w_grant) begin
        r_owner_d <= w_sel_d;
        r_last_d  <= w_sel_d;
      end
    end
  end

  // Transfer attributes latched at grant, write data, and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_hsize   <= 3'b000;
      r_wdata   <= '0;
      r_hwdata  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_haddr  <= w_sel_d ? bus.d_addr : bus.i_addr;
        r_hwrite <= w_sel_d && bus.d_we;
        r_hsize  <= w_sel_d ? {1'b0, bus.d_size} : HSIZE_WORD;
        r_wdata  <= bus.d_wdata;
      end
      if (w_hwdata_ld) r_hwdata <= r_wdata;
      if (w_capture) begin
        if (r_owner_d) begin
          r_d_err <= bus.HRESP;
          if (!r_hwrite) r_d_rdata <= bus.HRDATA;
        end else begin
          r_i_err   <= bus.HRESP;
          r_i_rdata <= bus.HRDATA;
        end
      end
    end
  end

  assign bus.HADDR   = r_haddr;
  assign bus.HTRANS  = r_htrans;
  assign bus.HWRITE  = r_hwrite;
  assign bus.HSIZE   = r_hsize;
  assign bus.HWDATA  = r_hwdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.i_rdata = r_i_rdata;
  assign bus.i_err   = r_i_err;
  assign bus.d_ack   = r_d_ack;
  assign bus.d_rdata = r_d_rdata;
  assign bus.d_err   = r_d_err;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench: round-robin DUT plus a fixed-priority DUT fed identical stimulus.
module tb_core_mem_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_if0 ();
  core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) u_if1 ();

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) u_dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if0)
  );

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) u_dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if1)
  );

  // Second DUT sees exactly the same requests and slave responses
  assign u_if1.i_req   = u_if0.i_req;
  assign u_if1.i_addr  = u_if0.i_addr;
  assign u_if1.d_req   = u_if0.d_req;
  assign u_if1.d_we    = u_if0.d_we;
  assign u_if1.d_size  = u_if0.d_size;
  assign u_if1.d_addr  = u_if0.d_addr;
  assign u_if1.d_wdata = u_if0.d_wdata;
  assign u_if1.HRDATA  = u_if0.HRDATA;
  assign u_if1.HREADY  = u_if0.HREADY;
  assign u_if1.HRESP   = u_if0.HRESP;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (u_if0.HTRANS == 2'b10) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    reset          = 1'b1;
    u_if0.i_req    = 1'b0;
    u_if0.i_addr   = '0;
    u_if0.d_req    = 1'b0;
    u_if0.d_we     = 1'b0;
    u_if0.d_size   = 2'd0;
    u_if0.d_addr   = '0;
    u_if0.d_wdata  = '0;
    u_if0.HRDATA   = '0;
    u_if0.HREADY   = 1'b1;
    u_if0.HRESP    = 1'b0;

    // Reset state
    tick(2);
    chk("rst_htrans", 64'(u_if0.HTRANS), 64'h0);
    chk("rst_haddr",  64'(u_if0.HADDR),  64'h0);
    chk("rst_acks",   64'({u_if0.i_ack, u_if0.d_ack}), 64'h0);
    chk("rst_rdata",  64'({u_if0.i_rdata, u_if0.d_rdata}), 64'h0);
    reset = 1'b0;
    tick();

    // Fetch only, zero-wait slave
    u_if0.i_req  = 1'b1;
    u_if0.i_addr = 32'h0000_0100;
    u_if0.HRDATA = 32'h0010_0093;
    tick();
    chk("f_htrans",  64'(u_if0.HTRANS), 64'h2);
    chk("f_haddr",   64'(u_if0.HADDR),  64'h100);
    chk("f_hsize",   64'(u_if0.HSIZE),  64'h2);
    chk("f_hwrite",  64'(u_if0.HWRITE), 64'h0);
    tick();
    chk("f_htrans_idle", 64'(u_if0.HTRANS), 64'h0);
    chk("f_ack_early",   64'(u_if0.i_ack),  64'h0);
    tick();
    chk("f_ack",   64'(u_if0.i_ack),   64'h1);
    chk("f_rdata", 64'(u_if0.i_rdata), 64'h0010_0093);
    chk("f_dack",  64'(u_if0.d_ack),   64'h0);
    u_if0.i_req = 1'b0;
    tick();
    chk("f_ack_pulse", 64'(u_if0.i_ack), 64'h0);

    // Store, two wait states in the data phase
    u_if0.d_req   = 1'b1;
    u_if0.d_we    = 1'b1;
    u_if0.d_size  = 2'd1;
    u_if0.d_addr  = 32'h2000_0004;
    u_if0.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_htrans", 64'(u_if0.HTRANS), 64'h2);
    chk("st_haddr",  64'(u_if0.HADDR),  64'h2000_0004);
    chk("st_hwrite", 64'(u_if0.HWRITE), 64'h1);
    chk("st_hsize",  64'(u_if0.HSIZE),  64'h1);
    tick();
    u_if0.HREADY = 1'b0;
    chk("st_hwdata",  64'(u_if0.HWDATA), 64'hDEAD_BEEF);
    chk("st_htrans0", 64'(u_if0.HTRANS), 64'h0);
    tick();
    chk("st_hwdata_w1", 64'(u_if0.HWDATA), 64'hDEAD_BEEF);
    chk("st_ack_w1",    64'(u_if0.d_ack),  64'h0);
    tick();
    chk("st_ack_w2",    64'(u_if0.d_ack),  64'h0);
    u_if0.HREADY = 1'b1;
    tick();
    chk("st_ack",   64'(u_if0.d_ack),   64'h1);
    chk("st_err",   64'(u_if0.d_err),   64'h0);
    chk("st_rdata", 64'(u_if0.d_rdata), 64'h0);
    chk("st_iack",  64'(u_if0.i_ack),   64'h0);
    u_if0.d_req = 1'b0;
    tick();

    // Load with address-phase wait; d_addr change must not reach HADDR
    u_if0.d_req  = 1'b1;
    u_if0.d_we   = 1'b0;
    u_if0.d_size = 2'd2;
    u_if0.d_addr = 32'h0000_0040;
    u_if0.HRDATA = 32'h1122_3344;
    tick();
    u_if0.d_addr = 32'h0000_0080;
    u_if0.HREADY = 1'b0;
    tick();
    chk("aw_haddr",  64'(u_if0.HADDR),  64'h40);
    chk("aw_htrans", 64'(u_if0.HTRANS), 64'h2);
    u_if0.HREADY = 1'b1;
    tick();
    chk("aw_haddr_dp", 64'(u_if0.HADDR), 64'h40);
    tick();
    chk("aw_ack",   64'(u_if0.d_ack),   64'h1);
    chk("aw_rdata", 64'(u_if0.d_rdata), 64'h1122_3344);
    chk("aw_haddr_end", 64'(u_if0.HADDR), 64'h40);
    u_if0.d_req = 1'b0;
    tick();

    // Load with two-cycle error response, then a clean load
    u_if0.d_req  = 1'b1;
    u_if0.d_addr = 32'h3000_0000;
    u_if0.HRDATA = 32'h5555_AAAA;
    tick(2);
    u_if0.HREADY = 1'b0;
    u_if0.HRESP  = 1'b1;
    tick();
    chk("er_ack_first", 64'(u_if0.d_ack), 64'h0);
    u_if0.HREADY = 1'b1;
    tick();
    chk("er_ack", 64'(u_if0.d_ack), 64'h1);
    chk("er_err", 64'(u_if0.d_err), 64'h1);
    u_if0.HRESP = 1'b0;
    u_if0.d_req = 1'b0;
    tick();
    u_if0.d_req = 1'b1;
    tick(3);
    chk("er_next_ack", 64'(u_if0.d_ack), 64'h1);
    chk("er_next_err", 64'(u_if0.d_err), 64'h0);
    u_if0.d_req = 1'b0;
    tick();

    // Reset in the data phase of a fetch while a data request is pending
    u_if0.i_req  = 1'b1;
    u_if0.i_addr = 32'h0000_0500;
    u_if0.d_addr = 32'h0000_0600;
    tick();
    chk("ar_grant_i", 64'(u_if0.HADDR), 64'h500);
    u_if0.d_req = 1'b1;
    tick();
    u_if0.HREADY = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("ar_htrans", 64'(u_if0.HTRANS), 64'h0);
    chk("ar_haddr",  64'(u_if0.HADDR),  64'h0);
    chk("ar_attr",   64'({u_if0.HWRITE, u_if0.HSIZE}), 64'h0);
    chk("ar_hwdata", 64'(u_if0.HWDATA), 64'h0);
    chk("ar_rdata",  64'({u_if0.i_rdata, u_if0.d_rdata}), 64'h0);
    chk("ar_ackerr", 64'({u_if0.i_ack, u_if0.d_ack, u_if0.i_err, u_if0.d_err}), 64'h0);
    u_if0.HREADY = 1'b1;
    tick(2);
    chk("ar_hold_ack",    64'({u_if0.i_ack, u_if0.d_ack}), 64'h0);
    chk("ar_hold_htrans", 64'(u_if0.HTRANS), 64'h0);
    reset = 1'b0;

    // Both requests held: RR alternates I,D,I,D; fixed priority always D
    for (int k = 0; k < 4; k++) begin
      wait_grant("tie_grant");
      chk("tie_rr_owner", 64'(u_if0.HADDR), (k % 2 == 0) ? 64'h500 : 64'h600);
      chk("tie_fp_owner", 64'(u_if1.HADDR), 64'h600);
      chk("tie_fp_htrans", 64'(u_if1.HTRANS), 64'h2);
    end
    tick(2);
    chk("tie_rr_dack", 64'(u_if0.d_ack), 64'h1);
    chk("tie_fp_dack", 64'(u_if1.d_ack), 64'h1);
    u_if0.d_req = 1'b0;
    wait_grant("drop_grant");
    chk("drop_rr_owner", 64'(u_if0.HADDR), 64'h500);
    chk("drop_fp_owner", 64'(u_if1.HADDR), 64'h500);
    tick(2);
    chk("drop_rr_iack", 64'(u_if0.i_ack), 64'h1);
    chk("drop_fp_iack", 64'(u_if1.i_ack), 64'h1);
    u_if0.i_req = 1'b0;
    tick(3);
    chk("end_idle", 64'({u_if0.HTRANS, u_if1.HTRANS}), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
